// File: rtl/flag_unit.sv
// Four-flag (Z,N,C,V) status register with masked ALU load, a DEPTH-entry
// save/restore stack for interrupts and calls, and a branch-condition evaluator.
module flag_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_ovf,
    input  logic             ld,
    input  logic [3:0]       ld_mask,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [3:0]       cond,
    output logic [3:0]       flags,
    output logic             cond_true,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SLOTS = 1 << IDX_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [3:0]       stack_mem [SLOTS];
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [3:0]       alu_flags;
    logic             push_ok;
    logic             pop_ok;
    logic             err_set;
    logic             ld_apply;

    function automatic logic eval_cond(input logic [3:0] f, input logic [3:0] c);
        logic z, n, cy, v;
        logic res;
        z   = f[3];
        n   = f[2];
        cy  = f[1];
        v   = f[0];
        res = 1'b0;
        case (c)
            4'd0:  res = 1'b1;
            4'd1:  res = z;
            4'd2:  res = !z;
            4'd3:  res = cy;
            4'd4:  res = !cy;
            4'd5:  res = n;
            4'd6:  res = !n;
            4'd7:  res = v;
            4'd8:  res = !v;
            4'd9:  res = n ^ v;
            4'd10: res = !(n ^ v);
            4'd11: res = z | (n ^ v);
            4'd12: res = !z & !(n ^ v);
            4'd13: res = cy & !z;
            4'd14: res = !cy | z;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    assign stack_full  = (count == FULL_CNT);
    assign stack_empty = (count == '0);
    assign wr_idx      = IDX_W'(count);
    assign rd_idx      = IDX_W'(count - CNT_W'(1));
    assign alu_flags   = {(alu_out == '0), alu_out[WIDTH-1], alu_carry, alu_ovf};

    // A requested pop always suppresses ld, even when the pop itself is rejected.
    assign push_ok  = push && !pop && !stack_full;
    assign pop_ok   = pop && !push && !stack_empty;
    assign ld_apply = ld && !pop;
    assign err_set  = (push && pop) || (push && !pop && stack_full) ||
                      (pop && !push && stack_empty);

    always_ff @(posedge clk) begin
        if (!reset) begin
            flags     <= 4'b0000;
            count     <= '0;
            stack_err <= 1'b0;
        end else begin
            if (pop_ok) begin
                flags <= stack_mem[rd_idx];
                count <= count - CNT_W'(1);
            end else begin
                if (ld_apply)
                    flags <= (ld_mask & alu_flags) | (~ld_mask & flags);
                if (push_ok)
                    count <= count + CNT_W'(1);
            end
            if (err_set)
                stack_err <= 1'b1;
            else if (clr_err)
                stack_err <= 1'b0;
        end
    end

    // Storage is data only; its contents after reset are don't-care.
    always_ff @(posedge clk) begin
        if (push_ok)
            stack_mem[wr_idx] <= flags;
    end

    assign cond_true = eval_cond(flags, cond);

endmodule

// File: tb/tb_flag_unit.sv
// Directed self-checking bench for flag_unit: reset, masked load, stack,
// simultaneous events, condition codes, mid-operation reset and a wide/shallow instance.
module tb_flag_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  alu_out;
    logic [15:0] alu_out16;
    logic        alu_carry, alu_ovf, ld, push, pop, clr_err;
    logic [3:0]  ld_mask, cond;
    logic [3:0]  flags, flags16;
    logic        cond_true, stack_full, stack_empty, stack_err;
    logic        cond_true16, stack_full16, stack_empty16, stack_err16;

    int checks;
    int failures;

    flag_unit #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .alu_out(alu_out), .alu_carry(alu_carry),
        .alu_ovf(alu_ovf), .ld(ld), .ld_mask(ld_mask), .push(push), .pop(pop),
        .clr_err(clr_err), .cond(cond), .flags(flags), .cond_true(cond_true),
        .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
    );

    flag_unit #(.WIDTH(16), .DEPTH(1)) dut16 (
        .clk(clk), .reset(reset), .alu_out(alu_out16), .alu_carry(alu_carry),
        .alu_ovf(alu_ovf), .ld(ld), .ld_mask(ld_mask), .push(push), .pop(pop),
        .clr_err(clr_err), .cond(cond), .flags(flags16), .cond_true(cond_true16),
        .stack_full(stack_full16), .stack_empty(stack_empty16), .stack_err(stack_err16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ld = 0; push = 0; pop = 0; clr_err = 0; ld_mask = 4'b0000;
    endtask

    // One full-mask load, inputs cleared afterwards.
    task automatic load(input logic [7:0] a, input logic c, input logic v);
        alu_out = a; alu_carry = c; alu_ovf = v; ld = 1; ld_mask = 4'b1111;
        tick();
        idle();
    endtask

    function automatic logic cond_ref(input logic [3:0] f, input int c);
        logic z, n, cy, v;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        case (c)
            0: return 1'b1;
            1: return z;
            2: return ~z;
            3: return cy;
            4: return ~cy;
            5: return n;
            6: return ~n;
            7: return v;
            8: return ~v;
            9: return n != v;
            10: return n == v;
            11: return z || (n != v);
            12: return !z && (n == v);
            13: return cy && !z;
            14: return !cy || z;
            default: return 1'b0;
        endcase
    endfunction

    task automatic test_reset;
        reset = 0; ld = 1; push = 1; ld_mask = 4'b1111; alu_out = 8'h80; alu_carry = 1; alu_ovf = 1;
        tick(); tick();
        checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        checks++; if ({stack_empty, stack_full, stack_err} !== 3'b100) begin failures++;
            $display("FAIL reset_status got e/f/err=%b exp=100", {stack_empty, stack_full, stack_err}); end
        idle();
        reset = 1;
        load(8'h00, 1'b1, 1'b0);
        cond = 4'd1;
        checks++; if (flags !== 4'b1010) begin failures++; $display("FAIL first_load got=%b exp=1010", flags); end
        checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL first_cond_z got=%b exp=1", cond_true); end
    endtask

    task automatic test_masked_load;
        alu_out = 8'h83; alu_carry = 0; alu_ovf = 0; ld = 1; ld_mask = 4'b0100;
        tick(); idle();
        checks++; if (flags !== 4'b1110) begin failures++; $display("FAIL mask_n got=%b exp=1110", flags); end
        alu_out = 8'h0D; ld = 1; ld_mask = 4'b1000;
        tick(); idle();
        checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL mask_z got=%b exp=0110", flags); end
        alu_out = 8'h00; alu_carry = 1; alu_ovf = 1; ld = 1; ld_mask = 4'b0000;
        tick(); idle();
        checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL mask_none got=%b exp=0110", flags); end
    endtask

    task automatic test_stack;
        logic [7:0] a_tab [4] = '{8'h01, 8'h01, 8'h80, 8'h00};
        logic       c_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       v_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] f_tab [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 4; i++) begin
            load(a_tab[i], c_tab[i], v_tab[i]);
            checks++; if (flags !== f_tab[i]) begin failures++;
                $display("FAIL stack_load%0d got=%b exp=%b", i, flags, f_tab[i]); end
            push = 1; tick(); idle();
        end
        checks++; if (stack_full !== 1'b1 || stack_err !== 1'b0) begin failures++;
            $display("FAIL stack_full got full=%b err=%b exp full=1 err=0", stack_full, stack_err); end
        push = 1; tick(); idle();
        checks++; if (stack_err !== 1'b1 || stack_full !== 1'b1) begin failures++;
            $display("FAIL push_overflow got err=%b full=%b exp 1 1", stack_err, stack_full); end
        for (int i = 3; i >= 0; i--) begin
            pop = 1; tick(); idle();
            checks++; if (flags !== f_tab[i]) begin failures++;
                $display("FAIL pop%0d got=%b exp=%b", 3 - i, flags, f_tab[i]); end
        end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin failures++;
            $display("FAIL stack_empty got empty=%b full=%b exp 1 0", stack_empty, stack_full); end
        pop = 1; tick(); idle();
        checks++; if (flags !== 4'b0001 || stack_err !== 1'b1 || stack_empty !== 1'b1) begin failures++;
            $display("FAIL pop_underflow got flags=%b err=%b empty=%b exp 0001 1 1", flags, stack_err, stack_empty); end
        clr_err = 1; tick(); idle();
        checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", stack_err); end
    endtask

    task automatic test_back_to_back;
        load(8'h01, 1'b0, 1'b0);
        checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL b2b_setup got=%b exp=0000", flags); end
        push = 1; ld = 1; ld_mask = 4'b1111; alu_out = 8'hC4; alu_carry = 0; alu_ovf = 0;
        tick(); idle();
        checks++; if (flags !== 4'b0100 || stack_empty !== 1'b0) begin failures++;
            $display("FAIL push_ld got flags=%b empty=%b exp 0100 0", flags, stack_empty); end
        pop = 1; ld = 1; ld_mask = 4'b1111; alu_out = 8'h00; alu_carry = 1; alu_ovf = 1;
        tick(); idle();
        checks++; if (flags !== 4'b0000 || stack_empty !== 1'b1 || stack_err !== 1'b0) begin failures++;
            $display("FAIL pop_ld got flags=%b empty=%b err=%b exp 0000 1 0", flags, stack_empty, stack_err); end
        push = 1; tick(); idle();
        push = 1; pop = 1; ld = 1; ld_mask = 4'b1111; alu_out = 8'h00;
        tick(); idle();
        checks++; if (stack_err !== 1'b1 || flags !== 4'b0000 || stack_empty !== 1'b0 || stack_full !== 1'b0) begin
            failures++;
            $display("FAIL push_pop got err=%b flags=%b empty=%b full=%b exp 1 0000 0 0",
                     stack_err, flags, stack_empty, stack_full); end
        pop = 1; tick(); idle();
        checks++; if (stack_empty !== 1'b1) begin failures++; $display("FAIL push_pop_count got empty=%b exp=1", stack_empty); end
        clr_err = 1; tick(); idle();
        pop = 1; clr_err = 1; tick(); idle();
        checks++; if (stack_err !== 1'b1) begin failures++; $display("FAIL err_set_wins got=%b exp=1", stack_err); end
        clr_err = 1; tick(); idle();
        checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL clr_err2 got=%b exp=0", stack_err); end
    endtask

    task automatic test_conditions;
        int          ci [4] = '{9, 10, 11, 12};
        logic        ce [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  f;
        load(8'h80, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cond = ci[i]; #1;
            checks++; if (cond_true !== ce[i]) begin failures++;
                $display("FAIL cond%0d_nv got=%b exp=%b", ci[i], cond_true, ce[i]); end
        end
        load(8'h01, 1'b1, 1'b0);
        cond = 4'd13; #1;
        checks++; if (cond_true !== 1'b1) begin failures++; $display("FAIL cond13 got=%b exp=1", cond_true); end
        cond = 4'd14; #1;
        checks++; if (cond_true !== 1'b0) begin failures++; $display("FAIL cond14 got=%b exp=0", cond_true); end
        for (int fv = 0; fv < 16; fv++) begin
            f = 4'(fv);
            alu_out = f[3] ? 8'h00 : 8'h01; ld = 1; ld_mask = 4'b1000;
            tick();
            alu_out = f[2] ? 8'h80 : 8'h01; alu_carry = f[1]; alu_ovf = f[0]; ld_mask = 4'b0111;
            tick(); idle();
            checks++; if (flags !== f) begin failures++; $display("FAIL sweep_flags got=%b exp=%b", flags, f); end
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c); #1;
                checks++; if (cond_true !== cond_ref(f, c)) begin failures++;
                    $display("FAIL cond%0d_flags%b got=%b exp=%b", c, f, cond_true, cond_ref(f, c)); end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        load(8'h80, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            push = 1; tick(); idle();
        end
        checks++; if (stack_empty !== 1'b0 || stack_full !== 1'b0) begin failures++;
            $display("FAIL mid_setup got empty=%b full=%b exp 0 0", stack_empty, stack_full); end
        reset = 0; pop = 1; tick(); idle(); reset = 1;
        checks++; if (flags !== 4'b0000 || stack_empty !== 1'b1 || stack_full !== 1'b0 || stack_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op got flags=%b empty=%b full=%b err=%b exp 0000 1 0 0",
                     flags, stack_empty, stack_full, stack_err); end
    endtask

    task automatic test_wide_shallow;
        alu_out16 = 16'h8000; alu_carry = 0; alu_ovf = 0; ld = 1; ld_mask = 4'b1111;
        tick(); idle();
        checks++; if (flags16 !== 4'b0100) begin failures++; $display("FAIL wide_n15 got=%b exp=0100", flags16); end
        alu_out16 = 16'h0080; ld = 1; ld_mask = 4'b1111;
        tick(); idle();
        checks++; if (flags16 !== 4'b0000) begin failures++; $display("FAIL wide_bit7 got=%b exp=0000", flags16); end
        checks++; if (stack_empty16 !== 1'b1 || stack_full16 !== 1'b0) begin failures++;
            $display("FAIL wide_empty got empty=%b full=%b exp 1 0", stack_empty16, stack_full16); end
        push = 1; tick(); idle();
        checks++; if (stack_full16 !== 1'b1 || stack_empty16 !== 1'b0 || stack_err16 !== 1'b0) begin failures++;
            $display("FAIL wide_full got full=%b empty=%b err=%b exp 1 0 0", stack_full16, stack_empty16, stack_err16); end
        push = 1; tick(); idle();
        checks++; if (stack_err16 !== 1'b1 || stack_full16 !== 1'b1) begin failures++;
            $display("FAIL wide_overflow got err=%b full=%b exp 1 1", stack_err16, stack_full16); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 0; alu_out = 8'h00; alu_out16 = 16'h0000; alu_carry = 0; alu_ovf = 0;
        cond = 4'd0;
        idle();
        test_reset();
        test_masked_load();
        test_stack();
        test_back_to_back();
        test_conditions();
        test_reset_mid_op();
        test_wide_shallow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
